// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM states, SPI mode encoding
// and the helpers that pick shift/sample edges from the latched mode.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
  function automatic logic sample_now(input spi_mode_t m, input logic lead, input logic trail);
    return m.cpha ? trail : lead;
  endfunction

  // CPHA=0 already presented the MSB at setup, so it shifts on trailing edges
  // except the last; CPHA=1 presents each bit on its leading edge.
  function automatic logic shift_now(input spi_mode_t m, input logic lead, input logic trail,
                                     input logic last);
    return m.cpha ? lead : (trail & ~last);
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK timing for the SPI master: CLK_DIV half-period divider plus edge counter,
// producing leading/trailing edge strobes while edge counting is enabled.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int EC_W    = 5
) (
  input  logic            mclk,
  input  logic            reset,
  input  logic            run,
  input  logic            count_en,
  output logic            tick,
  output logic            lead_edge,
  output logic            trail_edge,
  output logic [EC_W-1:0] edge_cnt
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt_r;
  logic [EC_W-1:0]  edge_cnt_r;

  assign tick       = run && (div_cnt_r == CNT_W'(CLK_DIV - 1));
  assign lead_edge  = tick && count_en && (edge_cnt_r[0] == 1'b0);
  assign trail_edge = tick && count_en && (edge_cnt_r[0] == 1'b1);
  assign edge_cnt   = edge_cnt_r;

  // Half-period divider and edge counter; both park at zero whenever not running.
  always_ff @(posedge mclk) begin
    if (reset || !run) begin
      div_cnt_r  <= {CNT_W{1'b0}};
      edge_cnt_r <= {EC_W{1'b0}};
    end else begin
      if (tick) begin
        div_cnt_r <= {CNT_W{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + CNT_W'(1);
      end
      if (tick && count_en) begin
        edge_cnt_r <= edge_cnt_r + EC_W'(1);
      end else begin
        edge_cnt_r <= edge_cnt_r;
      end
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master (width, divider, four modes, NUM_SS chip selects, rx
// valid/overrun). Optional SPI_LOOPBACK_EN adds a loopback input routing mosi to rx.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_SS  = 1,
  parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              load,
  input  logic              start,
  input  logic              read,
  input  logic [1:0]        mode,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              rx_valid,
  output logic              overrun,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [NUM_SS-1:0] cs_n
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EC_W  = $clog2(EDGES + 1);

  state_e            state_r, state_n_s;
  spi_mode_t         mode_r;
  logic [DATA_W-1:0] tx_hold_r, tx_sh_r, rx_sh_r, data_out_r, tx_word_s;
  logic [NUM_SS-1:0] cs_n_r;
  logic              busy_r, done_r, rx_valid_r, overrun_r, sclk_r, mosi_r;
  logic              tick_s, lead_s, trail_s, last_s, accept_s, cmpl_s, rx_bit_s;
  logic [EC_W-1:0]   edge_cnt_s;

  spi_clkgen #(
    .CLK_DIV (CLK_DIV),
    .EC_W    (EC_W)
  ) u_clkgen (
    .mclk       (mclk),
    .reset      (reset),
    .run        (state_r != IDLE),
    .count_en   (state_r == XFER),
    .tick       (tick_s),
    .lead_edge  (lead_s),
    .trail_edge (trail_s),
    .edge_cnt   (edge_cnt_s)
  );

  // Out-of-range chip selects never leave IDLE.
  assign accept_s  = (state_r == IDLE) && start && ({1'b0, ss_sel} < (SS_W + 1)'(NUM_SS));
  assign cmpl_s    = (state_r == HOLD) && tick_s;
  assign last_s    = trail_s && (edge_cnt_s == EC_W'(EDGES - 1));
  assign tx_word_s = load ? data_in : tx_hold_r;

`ifdef SPI_LOOPBACK_EN
  logic lb_r;
  assign rx_bit_s = lb_r ? mosi_r : miso;

  // Loopback select is latched with the rest of the transfer configuration.
  always_ff @(posedge mclk) begin
    if (reset) begin
      lb_r <= 1'b0;
    end else if (accept_s) begin
      lb_r <= loopback;
    end
  end
`else
  assign rx_bit_s = miso;
`endif

  // FSM state register.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // FSM next-state: each phase ends on a divider tick, XFER on its final edge.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_n_s = SETUP; else state_n_s = IDLE;
      SETUP:   if (tick_s)   state_n_s = XFER;  else state_n_s = SETUP;
      XFER:    if (last_s)   state_n_s = HOLD;  else state_n_s = XFER;
      HOLD:    if (tick_s)   state_n_s = IDLE;  else state_n_s = HOLD;
      default: state_n_s = IDLE;
    endcase
  end

  // Transfer datapath: TX hold, shift registers, pins and completion outputs.
  always_ff @(posedge mclk) begin
    if (reset) begin
      tx_hold_r  <= {DATA_W{1'b0}};
      tx_sh_r    <= {DATA_W{1'b0}};
      rx_sh_r    <= {DATA_W{1'b0}};
      data_out_r <= {DATA_W{1'b0}};
      mode_r     <= MODE0;
      cs_n_r     <= {NUM_SS{1'b1}};
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= cmpl_s;
      busy_r <= (state_n_s != IDLE);
      if (load && (state_r == IDLE)) begin
        tx_hold_r <= data_in;
      end
      if (accept_s) begin
        mode_r  <= spi_mode_t'(mode);
        cs_n_r  <= ~(NUM_SS'(1'b1) << ss_sel);
        sclk_r  <= mode[1];
        tx_sh_r <= mode[0] ? tx_word_s : (tx_word_s << 1);
        mosi_r  <= mode[0] ? 1'b0 : tx_word_s[DATA_W-1];
        rx_sh_r <= {DATA_W{1'b0}};
      end else if (cmpl_s) begin
        cs_n_r     <= {NUM_SS{1'b1}};
        mosi_r     <= 1'b0;
        data_out_r <= rx_sh_r;
      end else if (state_r == XFER) begin
        if (tick_s) begin
          sclk_r <= ~sclk_r;
        end
        if (shift_now(mode_r, lead_s, trail_s, last_s)) begin
          mosi_r  <= tx_sh_r[DATA_W-1];
          tx_sh_r <= tx_sh_r << 1;
        end
        if (sample_now(mode_r, lead_s, trail_s)) begin
          rx_sh_r <= {rx_sh_r[DATA_W-2:0], rx_bit_s};
        end
      end
    end
  end

  // Sticky receive status; a read coinciding with completion cannot clear the new word.
  always_ff @(posedge mclk) begin
    if (reset) begin
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else if (cmpl_s) begin
      rx_valid_r <= 1'b1;
      if (rx_valid_r && !read) begin
        overrun_r <= 1'b1;
      end
    end else if (read) begin
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end
  end

  assign data_out = data_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign rx_valid = rx_valid_r;
  assign overrun  = overrun_r;
  assign sclk     = sclk_r;
  assign mosi     = mosi_r;
  assign cs_n     = cs_n_r;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: a behavioural SPI slave plus a host-side status model;
// under SPI_LOOPBACK_EN it also drives the loopback input.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int NS  = 3;
  localparam int SW  = 2;
  localparam int LAT = 1 + (2 * DW + 2) * CD;

  logic          mclk = 1'b0;
  logic          reset, load, start, read, miso, lb;
  logic [1:0]    mode;
  logic [SW-1:0] ss_sel;
  logic [DW-1:0] data_in, data_out;
  logic          busy, done, rx_valid, overrun, sclk, mosi;
  logic [NS-1:0] cs_n;

  int n_cmp  = 0;
  int n_fail = 0;
  logic m_valid = 1'b0;
  logic m_over  = 1'b0;

  spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_SS(NS)) dut (
    .mclk(mclk), .reset(reset), .load(load), .start(start), .read(read),
    .mode(mode), .ss_sel(ss_sel), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .rx_valid(rx_valid), .overrun(overrun),
    .sclk(sclk), .mosi(mosi), .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb),
`endif
    .cs_n(cs_n)
  );

  always #5 mclk = ~mclk;

  // Behavioural slave: reacts to sclk transitions seen at the falling mclk edge.
  logic [1:0]    cur_mode = 2'd0;
  int            cur_ss = 0;
  logic [DW-1:0] slv_word = '0;
  logic [DW-1:0] slv_cap = '0;
  int            slv_edges = 0;
  logic          prev_sclk = 1'b0;
  logic          prev_act = 1'b0;
  logic          act_s;
  assign act_s = (cs_n[cur_ss] === 1'b0);

  always @(negedge mclk) begin
    prev_sclk <= sclk;
    prev_act  <= act_s;
    if (act_s && !prev_act) begin
      slv_edges <= 0;
      slv_cap   <= '0;
      miso      <= cur_mode[0] ? 1'b0 : slv_word[DW-1];
    end else if (act_s && (sclk !== prev_sclk)) begin
      slv_edges <= slv_edges + 1;
      if (slv_edges[0] == 1'b0) begin
        if (!cur_mode[0]) slv_cap <= {slv_cap[DW-2:0], mosi};
        else              miso <= slv_word[DW-1-slv_edges/2];
      end else begin
        if (!cur_mode[0]) begin
          if (slv_edges/2 + 1 < DW) miso <= slv_word[DW-2-slv_edges/2];
        end else begin
          slv_cap <= {slv_cap[DW-2:0], mosi};
        end
      end
    end else if (!act_s) begin
      miso <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, " cs_n"}, 32'(cs_n), 32'(3'b111));
    chk({tag, " sclk"}, 32'(sclk), 32'd0);
    chk({tag, " mosi"}, 32'(mosi), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " data_out"}, 32'(data_out), 32'd0);
    chk({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, " overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic do_read(input string tag);
    @(negedge mclk); read = 1'b1;
    @(negedge mclk); read = 1'b0;
    m_valid = 1'b0; m_over = 1'b0;
    chk({tag, " rx_valid"}, 32'(rx_valid), 32'(m_valid));
    chk({tag, " overrun"}, 32'(overrun), 32'(m_over));
  endtask

  // One full transfer; optionally disturbs XFER or reads in the completion cycle.
  task automatic xfer(input string tag, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                      input logic [1:0] md, input int ss, input bit same_cycle,
                      input bit disturb, input bit rd_cmpl);
    int k;
    bit busy_ok;
    logic [NS-1:0] exp_cs;
    logic [DW-1:0] exp_rx;
    exp_cs = '1;
    exp_cs[ss] = 1'b0;
    exp_rx = lb ? tx : sw;
    cur_mode = md; cur_ss = ss; slv_word = sw;
    @(negedge mclk);
    load = 1'b1; data_in = tx;
    if (!same_cycle) begin
      @(negedge mclk);
      load = 1'b0; data_in = ~tx;
    end
    start = 1'b1; mode = md; ss_sel = SW'(ss);
    @(negedge mclk);
    start = 1'b0; load = 1'b0; data_in = DW'($urandom);
    chk({tag, " busy@T+1"}, 32'(busy), 32'd1);
    chk({tag, " cs_n"}, 32'(cs_n), 32'(exp_cs));
    chk({tag, " sclk idle"}, 32'(sclk), 32'(md[1]));
    k = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && k < LAT + 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (disturb && k == LAT / 2) begin
        start = 1'b1; load = 1'b1; data_in = '1; mode = ~md; ss_sel = '0;
      end else if (disturb && k == LAT / 2 + 1) begin
        start = 1'b0; load = 1'b0;
      end
      if (rd_cmpl && k == LAT - 1) read = 1'b1;
      @(negedge mclk);
      k++;
    end
    read = 1'b0;
    chk({tag, " done cycle"}, 32'(k), 32'(LAT));
    chk({tag, " busy held"}, 32'(busy_ok), 32'd1);
    chk({tag, " busy@done"}, 32'(busy), 32'd0);
    chk({tag, " data_out"}, 32'(data_out), 32'(exp_rx));
    chk({tag, " slave got"}, 32'(slv_cap), 32'(tx));
    chk({tag, " sclk edges"}, 32'(slv_edges), 32'(2 * DW));
    chk({tag, " cs_n@done"}, 32'(cs_n), 32'(3'b111));
    chk({tag, " sclk@done"}, 32'(sclk), 32'(md[1]));
    chk({tag, " mosi@done"}, 32'(mosi), 32'd0);
    if (!rd_cmpl && m_valid) m_over = 1'b1;
    m_valid = 1'b1;
    chk({tag, " rx_valid"}, 32'(rx_valid), 32'(m_valid));
    chk({tag, " overrun"}, 32'(overrun), 32'(m_over));
    @(negedge mclk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    if (disturb) begin
      repeat (4) @(negedge mclk);
      chk({tag, " no restart"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; read = 1'b0; lb = 1'b0;
    mode = 2'd0; ss_sel = '0; data_in = '0;
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    check_idle_reset("reset");

    xfer("m0", 8'hA5, 8'h3C, 2'd0, 0, 1'b0, 1'b0, 1'b0);
    xfer("m3", 8'h81, 8'h7E, 2'd3, 1, 1'b1, 1'b0, 1'b0);
    do_read("read1");

    @(negedge mclk); start = 1'b1; ss_sel = 2'd3; data_in = 8'h55; load = 1'b1;
    @(negedge mclk); start = 1'b0; load = 1'b0;
    chk("bad ss busy", 32'(busy), 32'd0);
    repeat (3) @(negedge mclk);
    chk("bad ss cs_n", 32'(cs_n), 32'(3'b111));

    xfer("disturb", DW'($urandom), DW'($urandom), 2'd1, 2, 1'b0, 1'b1, 1'b0);
    xfer("rd@cmpl", DW'($urandom), DW'($urandom), 2'd2, 0, 1'b1, 1'b0, 1'b1);

    @(negedge mclk); data_in = 8'hC3; load = 1'b1; start = 1'b1; ss_sel = 2'd1; mode = 2'd0;
    cur_ss = 1; cur_mode = 2'd0;
    @(negedge mclk); load = 1'b0; start = 1'b0;
    repeat (20) @(negedge mclk);
    reset = 1'b1;
    @(negedge mclk); reset = 1'b0;
    m_valid = 1'b0; m_over = 1'b0;
    check_idle_reset("midreset");
    repeat (CD * 4) @(negedge mclk);
    chk("midreset no done", 32'(done), 32'd0);
    xfer("after reset", 8'h5A, 8'hE1, 2'd1, 1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(1, 0) == 1) do_read("rnd read");
      xfer("rnd", DW'($urandom), DW'($urandom), 2'($urandom_range(3, 0)),
           int'($urandom_range(NS - 1, 0)), 1'($urandom_range(1, 0)), 1'b0, 1'b0);
    end

`ifdef SPI_LOOPBACK_EN
    lb = 1'b1;
    xfer("loopback", 8'hBE, 8'h11, 2'd0, 2, 1'b1, 1'b0, 1'b0);
    xfer("loopback m3", 8'hEF, 8'h22, 2'd3, 0, 1'b0, 1'b0, 1'b0);
    lb = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
